mips_mem_arbiter: RTL and testbench

- Arbitrates between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) for one shared, variable-latency unified memory port in the 5-stage pipeline.
- Issues one transaction at a time and raises per-requester stall signals that the pipeline control merges into PCWrite/IF_IDWrite gating.
- Discards fetches squashed by a branch flush.
- Aborts transactions that exceed a timeout.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/mips_mem_timeout.sv | 36 +++
 rtl/mips_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the IF/MEM unified memory arbiter.
package mips_mem_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/mips_mem_timeout.sv
// Busy-cycle counter: flags the last allowed busy cycle of a transaction.
module mips_mem_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expire on the TIMEOUT-th enabled cycle; TIMEOUT of 0 never expires.
  assign expired = (TIMEOUT != 0) && en && !clr && (cnt_q == LAST);

  // Next count: cleared outside busy, advanced while busy.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one variable-latency memory port.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  grant_t            grant_q, grant_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic if_pend, d_pend, busy, timed_out, drop_now;

  assign if_pend  = if_req & ~if_flush;
  assign d_pend   = d_read | d_write;
  assign busy     = (state_q == BUSY_IF) || (state_q == BUSY_D);
  assign drop_now = drop_q | if_flush;

  mips_mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (~busy),
    .en      (busy),
    .expired (timed_out)
  );

  // Next-state and output computation for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (d_pend && (!if_pend || grant_q == GRANT_IF)) begin
          grant_d     = GRANT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          state_d     = BUSY_D;
        end else if (if_pend) begin
          grant_d    = GRANT_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          state_d    = BUSY_IF;
        end
      end
      BUSY_IF: begin
        drop_d = drop_now;
        if (mem_ack || timed_out) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (!drop_now) begin
            if_ack_d   = 1'b1;
            bus_err_d  = ~mem_ack;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end
      end
      BUSY_D: begin
        if (mem_ack || timed_out) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          d_ack_d   = 1'b1;
          bus_err_d = ~mem_ack;
          if (!mem_ack)      d_rdata_d = '0;
          else if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
      RESP: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= GRANT_IF;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Stalls are combinational so the pipeline sees them in the request cycle.
  assign if_stall = ~rst & if_req & ~if_ack_q;
  assign d_stall  = ~rst & (d_read | d_write) & ~d_ack_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed, table-driven bench for mips_mem_arbiter (TIMEOUT=8).
module tb_mips_mem_arbiter;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        bus_err;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
    logic chk;
  } vec_t;

  logic        clk, rst;
  logic        if_req, if_flush, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_read, d_write, d_ack, d_stall, bus_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];
  in_t  cur_in;
  exp_t cur_ex;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic c);
    vec_t v;
    v.i = cur_in;
    v.e = cur_ex;
    v.chk = c;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t v);
    rst       = v.rst;
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    if_flush  = v.if_flush;
    d_read    = v.d_read;
    d_write   = v.d_write;
    d_addr    = v.d_addr;
    d_wdata   = v.d_wdata;
    mem_ack   = v.mem_ack;
    mem_rdata = v.mem_rdata;
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e, input int idx);
    cmp("mem_req",   idx, 32'(mem_req),  32'(e.mem_req));
    cmp("mem_we",    idx, 32'(mem_we),   32'(e.mem_we));
    cmp("mem_addr",  idx, mem_addr,      e.mem_addr);
    cmp("mem_wdata", idx, mem_wdata,     e.mem_wdata);
    cmp("if_ack",    idx, 32'(if_ack),   32'(e.if_ack));
    cmp("if_rdata",  idx, if_rdata,      e.if_rdata);
    cmp("if_stall",  idx, 32'(if_stall), 32'(e.if_stall));
    cmp("d_ack",     idx, 32'(d_ack),    32'(e.d_ack));
    cmp("d_rdata",   idx, d_rdata,       e.d_rdata);
    cmp("d_stall",   idx, 32'(d_stall),  32'(e.d_stall));
    cmp("bus_err",   idx, 32'(bus_err),  32'(e.bus_err));
  endtask

  // One cycle: drive inputs just after the edge, sample mid-cycle.
  task automatic run_one(input logic c, input int idx);
    @(posedge clk);
    #1;
    drive(cur_in);
    #4;
    if (c) check_all(cur_ex, idx);
  endtask

  initial begin
    cur_in = '0;
    cur_ex = '0;
    cur_in.rst = 1'b1;
    drive(cur_in);

    // Reset, then quiet idle; a stray mem_ack in IDLE is ignored.
    push(1'b0); push(1'b1);
    cur_in.rst = 1'b0;
    cur_in.mem_ack = 1'b1; push(1'b1);
    cur_in.mem_ack = 1'b0; push(1'b1); push(1'b1);

    // Single fetch, mem_ack two cycles after mem_req rises.
    cur_in.if_req = 1; cur_in.if_addr = 32'h0040_0000; cur_ex.if_stall = 1; push(1);
    cur_ex.mem_req = 1; cur_ex.mem_addr = 32'h0040_0000; push(1);
    push(1);
    cur_in.mem_ack = 1; cur_in.mem_rdata = 32'h8C08_0004; push(1);
    cur_in.mem_ack = 0; cur_in.mem_rdata = 0;
    cur_ex.mem_req = 0; cur_ex.if_ack = 1; cur_ex.if_rdata = 32'h8C08_0004; cur_ex.if_stall = 0; push(1);
    cur_in.if_req = 0; cur_ex.if_ack = 0; push(1);

    // Reset again, then tie between fetch and store: data wins first.
    cur_in.rst = 1; push(0);
    cur_ex = '0; push(1);
    cur_in.rst = 0;
    cur_in.if_req = 1; cur_in.if_addr = 32'h0040_0004;
    cur_in.d_write = 1; cur_in.d_addr = 32'h1001_0000; cur_in.d_wdata = 32'hDEAD_BEEF;
    cur_ex.if_stall = 1; cur_ex.d_stall = 1; push(1);
    cur_ex.mem_req = 1; cur_ex.mem_we = 1; cur_ex.mem_addr = 32'h1001_0000; cur_ex.mem_wdata = 32'hDEAD_BEEF; push(1);
    cur_in.mem_ack = 1; cur_in.mem_rdata = 32'h1234_5678; push(1);
    cur_in.mem_ack = 0; cur_ex.mem_req = 0; cur_ex.d_ack = 1; cur_ex.d_stall = 0; push(1);
    cur_in.d_write = 0; cur_ex.d_ack = 0; push(1);
    cur_ex.mem_req = 1; cur_ex.mem_we = 0; cur_ex.mem_addr = 32'h0040_0004;
    cur_in.mem_ack = 1; cur_in.mem_rdata = 32'h2010_FFFF; push(1);
    cur_in.mem_ack = 0; cur_ex.mem_req = 0; cur_ex.if_ack = 1; cur_ex.if_rdata = 32'h2010_FFFF; cur_ex.if_stall = 0; push(1);
    cur_in.if_req = 0; cur_ex.if_ack = 0; push(1);

    // Fetch flushed while busy: no if_ack, then a load proceeds normally.
    cur_in.if_req = 1; cur_in.if_addr = 32'h0040_0008; cur_ex.if_stall = 1; push(1);
    cur_in.if_flush = 1; cur_ex.mem_req = 1; cur_ex.mem_addr = 32'h0040_0008; push(1);
    cur_in.if_flush = 0; cur_in.if_req = 0; cur_in.d_read = 1; cur_in.d_addr = 32'h1001_0010;
    cur_ex.if_stall = 0; cur_ex.d_stall = 1; push(1);
    push(1);
    cur_in.mem_ack = 1; cur_in.mem_rdata = 32'hBADB_AD00; push(1);
    cur_in.mem_ack = 0; cur_ex.mem_req = 0; push(1);
    push(1);
    cur_ex.mem_req = 1; cur_ex.mem_addr = 32'h1001_0010;
    cur_in.mem_ack = 1; cur_in.mem_rdata = 32'hCAFE_F00D; push(1);
    cur_in.mem_ack = 0; cur_ex.mem_req = 0; cur_ex.d_ack = 1; cur_ex.d_rdata = 32'hCAFE_F00D; cur_ex.d_stall = 0; push(1);
    cur_in.d_read = 0; cur_ex.d_ack = 0; push(1);

    // Load with no mem_ack: abort after 8 busy cycles with bus_err.
    cur_in.d_read = 1; cur_in.d_addr = 32'h1001_0020; cur_ex.d_stall = 1; push(1);
    cur_ex.mem_req = 1; cur_ex.mem_addr = 32'h1001_0020;
    for (int k = 0; k < 8; k++) push(1);
    cur_ex.mem_req = 0; cur_ex.d_ack = 1; cur_ex.bus_err = 1; cur_ex.d_rdata = 0; cur_ex.d_stall = 0; push(1);
    cur_in.d_read = 0; cur_ex.d_ack = 0; cur_ex.bus_err = 0; cur_in.mem_ack = 1; push(1);
    cur_in.mem_ack = 0; push(1);

    // mem_ack on the last allowed busy cycle beats the timeout.
    cur_in.d_read = 1; cur_in.d_addr = 32'h1001_0024; cur_ex.d_stall = 1; push(1);
    cur_ex.mem_req = 1; cur_ex.mem_addr = 32'h1001_0024;
    for (int k = 0; k < 7; k++) push(1);
    cur_in.mem_ack = 1; cur_in.mem_rdata = 32'h55AA_55AA; push(1);
    cur_in.mem_ack = 0; cur_ex.mem_req = 0; cur_ex.d_ack = 1; cur_ex.d_rdata = 32'h55AA_55AA; cur_ex.d_stall = 0; push(1);
    cur_in.d_read = 0; cur_ex.d_ack = 0; push(1);

    // Tie after a data grant: fetch wins, load follows.
    cur_in.if_req = 1; cur_in.if_addr = 32'h0040_000C; cur_in.d_read = 1; cur_in.d_addr = 32'h1001_0028;
    cur_ex.if_stall = 1; cur_ex.d_stall = 1; push(1);
    cur_ex.mem_req = 1; cur_ex.mem_addr = 32'h0040_000C; cur_in.mem_ack = 1; cur_in.mem_rdata = 32'h2402_0001; push(1);
    cur_in.mem_ack = 0; cur_ex.mem_req = 0; cur_ex.if_ack = 1; cur_ex.if_rdata = 32'h2402_0001; cur_ex.if_stall = 0; push(1);
    cur_in.if_req = 0; cur_ex.if_ack = 0; push(1);
    cur_ex.mem_req = 1; cur_ex.mem_addr = 32'h1001_0028; cur_in.mem_ack = 1; cur_in.mem_rdata = 32'h0000_002A; push(1);
    cur_in.mem_ack = 0; cur_ex.mem_req = 0; cur_ex.d_ack = 1; cur_ex.d_rdata = 32'h0000_002A; cur_ex.d_stall = 0; push(1);
    cur_in.d_read = 0; cur_ex.d_ack = 0; push(1);

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk);
      #1;
      drive(tbl[k].i);
      #4;
      if (tbl[k].chk) check_all(tbl[k].e, k);
    end

    // Reset in the middle of a store: transaction abandoned, no d_ack.
    cur_in.d_write = 1; cur_in.d_addr = 32'h1001_0030; cur_in.d_wdata = 32'h0BAD_F00D;
    cur_ex.d_stall = 1; run_one(1, 1000);
    cur_ex.mem_req = 1; cur_ex.mem_we = 1; cur_ex.mem_addr = 32'h1001_0030; cur_ex.mem_wdata = 32'h0BAD_F00D;
    run_one(1, 1001);
    cur_in.rst = 1; cur_ex.d_stall = 0; run_one(1, 1002);
    cur_in.rst = 0; cur_in.d_write = 0; cur_ex = '0; run_one(1, 1003);
    cur_in.mem_ack = 1; run_one(1, 1004);
    cur_in.mem_ack = 0; run_one(1, 1005);
    run_one(1, 1006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
